serial_adder_seq: RTL

//  Bit-serial N-bit adder. Reuses one full-adder cell (sum=A^B^C, carry=majority(A,B,C))

---
 rtl/serial_adder_seq_if.sv | 35 +++
 rtl/serial_adder_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle for serial_adder_seq. SERIAL_SUB_EN adds the sub/ovf signals.
interface serial_adder_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
`ifdef SERIAL_SUB_EN
    logic         sub;
    logic         ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_SUB_EN
        output sub,
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_SUB_EN
        input  sub,
        output ovf,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial N-bit adder: one full-adder cell reused LSB first over N cycles.
// Define SERIAL_SUB_EN to add subtraction (sub input) and signed overflow (ovf output).
module serial_adder_seq #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    serial_adder_seq_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t         state;
    state_t         state_next;
    logic           load;
    logic           step;
    logic           fin;
    logic           last;

    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   res_reg;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   sum_reg;
    logic           cout_reg;
    logic           done_reg;
    logic           s_bit;
    logic           c_next;
    logic           b_in_msk;
    logic           cin_eff;

`ifdef SERIAL_SUB_EN
    logic           c_msb;
    logic           ovf_reg;
    assign b_in_msk = bus.sub;
    assign cin_eff  = bus.sub ? 1'b1 : bus.cin;
    assign bus.ovf  = ovf_reg;
`else
    assign b_in_msk = 1'b0;
    assign cin_eff  = bus.cin;
`endif

    assign s_bit  = a_reg[0] ^ b_reg[0] ^ carry;
    assign c_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last)      state_next = FIN;
            FIN:                    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        load = (state == IDLE) && bus.start;
        step = (state == SHIFT);
        fin  = (state == FIN);
    end

    // Results are registered out of FIN so done, sum and cout change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            done_reg <= 1'b0;
`ifdef SERIAL_SUB_EN
            c_msb    <= 1'b0;
            ovf_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= fin;
            if (load) begin
                a_reg <= bus.a;
                b_reg <= b_in_msk ? ~bus.b : bus.b;
                carry <= cin_eff;
                cnt   <= '0;
            end else if (step) begin
                res_reg <= {s_bit, res_reg[N-1:1]};
                a_reg   <= a_reg >> 1;
                b_reg   <= b_reg >> 1;
                carry   <= c_next;
                cnt     <= cnt + CW'(1);
`ifdef SERIAL_SUB_EN
                if (last) c_msb <= carry;
`endif
            end
            if (fin) begin
                sum_reg  <= res_reg;
                cout_reg <= carry;
`ifdef SERIAL_SUB_EN
                ovf_reg  <= c_msb ^ carry;
`endif
            end
        end
    end

    assign bus.busy = step;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule
